// File: rtl/hamming_stream_encoder_pkg.sv
// hamming_pkg: shared Hamming code helpers and encoder state type
package hamming_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;

  function automatic int hamming_par_w(int dw);
    int r = 1;
    while ((1 << r) < dw + r + 1) r++;
    return r;
  endfunction

  // data bit i sits at the (i+1)-th non-power-of-two position: 3,5,6,7,9,...
  function automatic int hamming_pos(int i);
    int pos = 2;
    for (int n = 0; n <= i; n++) begin
      pos++;
      while ((pos & (pos - 1)) == 0) pos++;
    end
    return pos;
  endfunction

  function automatic logic [63:0] hamming_par_mask(int dw, int j);
    logic [63:0] m = '0;
    for (int i = 0; i < dw; i++) m[i] = ((hamming_pos(i) >> j) & 1) == 1;
    return m;
  endfunction
endpackage

// File: rtl/hamming_stream_encoder_if.sv
// hamming_stream_encoder_if: word input, serial bit output and codeword status bundle
interface hamming_stream_encoder_if #(parameter int DATA_W = 4, parameter int CW_W = 7);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              bit_out;
  logic              bit_valid;
  logic              bit_ready;
  logic              bit_first;
  logic              bit_last;
  logic [CW_W-1:0]   cw_out;
  logic              cw_valid;
  logic [15:0]       word_count;
  modport master (
    output in_data, in_valid, bit_ready,
    input  in_ready, bit_out, bit_valid, bit_first, bit_last, cw_out, cw_valid, word_count
  );
  modport slave (
    input  in_data, in_valid, bit_ready,
    output in_ready, bit_out, bit_valid, bit_first, bit_last, cw_out, cw_valid, word_count
  );
endinterface

// File: rtl/hamming_stream_encoder_parity_gen.sv
// hamming_parity_gen: combinational systematic Hamming / SECDED codeword builder
module hamming_parity_gen
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int PAR_W  = 3,
  parameter int EXT    = 0
) (
  input  logic [DATA_W-1:0]           i_data,
  output logic [DATA_W+PAR_W+EXT-1:0] o_cw
);
  logic [PAR_W-1:0] w_par;
  for (genvar j = 0; j < PAR_W; j++) begin : g_par
    localparam logic [63:0] MASK = hamming_par_mask(DATA_W, j);
    assign w_par[j] = ^(i_data & MASK[DATA_W-1:0]);
  end
  if (EXT != 0) begin : g_ext
    assign o_cw = {^{w_par, i_data}, w_par, i_data};
  end else begin : g_std
    assign o_cw = {w_par, i_data};
  end
endmodule

// File: rtl/hamming_stream_encoder.sv
// hamming_stream_encoder: accepts data words and shifts their Hamming codewords out MSB-first
module hamming_stream_encoder
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int PAR_W  = 3,
  parameter int EXT    = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  hamming_stream_encoder_if.slave   bus
);
  localparam int CW_W = DATA_W + PAR_W + EXT;
  localparam int CNT_W = $clog2(CW_W);
  localparam logic [CNT_W-1:0] TOP = CNT_W'(CW_W - 1);
  if (DATA_W < 1 || DATA_W > 57 || PAR_W != hamming_par_w(DATA_W) || EXT < 0 || EXT > 1) begin : g_bad_cfg
    $error("hamming_stream_encoder: illegal DATA_W/PAR_W/EXT combination");
  end
  state_t            r_state;
  logic [CW_W-1:0]   r_sh;
  logic [CW_W-1:0]   r_cw;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_cw_valid;
  logic [15:0]       r_wc;
  logic [CW_W-1:0]   w_cw;
  logic              w_valid, w_last, w_bit_hs, w_done, w_in_ready, w_accept;
  hamming_parity_gen #(.DATA_W(DATA_W), .PAR_W(PAR_W), .EXT(EXT)) u_gen (
    .i_data (bus.in_data),
    .o_cw   (w_cw)
  );
  assign w_valid    = r_state == SHIFT;
  assign w_last     = w_valid && r_cnt == '0;
  assign w_bit_hs   = w_valid && bus.bit_ready;
  assign w_done     = w_bit_hs && w_last;
  // the finishing bit handshake opens the input so frames run back to back
  assign w_in_ready = !w_valid || w_done;
  assign w_accept   = bus.in_valid && w_in_ready;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_sh       <= '0;
      r_cw       <= '0;
      r_cnt      <= '0;
      r_cw_valid <= 1'b0;
      r_wc       <= '0;
    end else begin
      r_cw_valid <= w_accept;
      if (w_done) r_wc <= r_wc + 16'd1;
      if (w_accept) begin
        r_state <= SHIFT;
        r_sh    <= w_cw;
        r_cw    <= w_cw;
        r_cnt   <= TOP;
      end else if (w_bit_hs) begin
        r_sh  <= r_sh << 1;
        r_cnt <= r_cnt - 1'b1;
        if (w_last) r_state <= IDLE;
      end
    end
  end
  assign bus.in_ready   = w_in_ready;
  assign bus.bit_out    = r_sh[CW_W-1];
  assign bus.bit_valid  = w_valid;
  assign bus.bit_first  = w_valid && r_cnt == TOP;
  assign bus.bit_last   = w_last;
  assign bus.cw_out     = r_cw;
  assign bus.cw_valid   = r_cw_valid;
  assign bus.word_count = r_wc;
endmodule

// File: tb/tb_hamming_stream_encoder.sv
// tb_hamming_stream_encoder: directed and randomized checks against a positional Hamming model
module tb_hamming_stream_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hamming_stream_encoder_if #(.DATA_W(4), .CW_W(7))   if0 ();
  hamming_stream_encoder_if #(.DATA_W(4), .CW_W(8))   if1 ();
  hamming_stream_encoder_if #(.DATA_W(11), .CW_W(15)) ifw ();

  hamming_stream_encoder #(.DATA_W(4), .PAR_W(3), .EXT(0)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(if0));
  hamming_stream_encoder #(.DATA_W(4), .PAR_W(3), .EXT(1)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(if1));
  hamming_stream_encoder #(.DATA_W(11), .PAR_W(4), .EXT(0)) dutw (.i_clk(clk), .i_rst_n(rst_n), .bus(ifw));

  function automatic int tb_pos(int i);
    int pos = 3;
    int n = 0;
    while (1) begin
      if ((pos & (pos - 1)) != 0) begin
        if (n == i) return pos;
        n++;
      end
      pos++;
    end
  endfunction

  // parity is the XOR of the positions of all set data bits
  function automatic logic [63:0] ref_cw(logic [63:0] d, int dw, int pw, int ext);
    logic [63:0] cw = '0;
    int syn = 0;
    for (int i = 0; i < dw; i++) begin
      cw[i] = d[i];
      if (d[i]) syn ^= tb_pos(i);
    end
    for (int j = 0; j < pw; j++) cw[dw+j] = syn[j];
    if (ext != 0) cw[dw+pw] = ^cw;
    return cw;
  endfunction

  function automatic int syndrome11(logic [14:0] cw);
    int s = 0;
    for (int i = 0; i < 11; i++) if (cw[i]) s ^= tb_pos(i);
    s ^= int'(cw[14:11]);
    return s;
  endfunction

  task automatic test_reset();
    #2;
    total++; if (if0.bit_valid !== 1'b0) begin bad++; $display("FAIL reset_bit_valid got=%b want=0", if0.bit_valid); end
    total++; if (if0.bit_out !== 1'b0) begin bad++; $display("FAIL reset_bit_out got=%b want=0", if0.bit_out); end
    total++; if ({if0.bit_first, if0.bit_last} !== 2'b00) begin bad++; $display("FAIL reset_first_last got=%b want=00", {if0.bit_first, if0.bit_last}); end
    total++; if (if0.cw_out !== 7'h00) begin bad++; $display("FAIL reset_cw_out got=%h want=00", if0.cw_out); end
    total++; if (if0.cw_valid !== 1'b0) begin bad++; $display("FAIL reset_cw_valid got=%b want=0", if0.cw_valid); end
    total++; if (if0.word_count !== 16'd0) begin bad++; $display("FAIL reset_word_count got=%0d want=0", if0.word_count); end
    total++; if (if0.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", if0.in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [6:0] s = '0;
    int n = 0, fpos = -1, lpos = -1, pulses = 0;
    if0.in_data = 4'b1011; if0.in_valid = 1'b1; if0.bit_ready = 1'b1;
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
    total++; if (if0.bit_valid !== 1'b1) begin bad++; $display("FAIL basic_latency bit_valid got=%b want=1", if0.bit_valid); end
    total++; if (if0.cw_out !== 7'h1B) begin bad++; $display("FAIL basic_cw_out got=%h want=1b", if0.cw_out); end
    for (int c = 0; c < 12; c++) begin
      if (if0.cw_valid) pulses++;
      if (if0.bit_valid) begin
        if (if0.bit_first) fpos = n;
        if (if0.bit_last) lpos = n;
        s = {s[5:0], if0.bit_out};
        n++;
      end
      @(posedge clk); #1;
    end
    total++; if (s !== 7'b0011011 || n != 7) begin bad++; $display("FAIL basic_serial got=%b n=%0d want=0011011 n=7", s, n); end
    total++; if (fpos != 0 || lpos != 6) begin bad++; $display("FAIL basic_first_last got=%0d/%0d want=0/6", fpos, lpos); end
    total++; if (pulses != 1) begin bad++; $display("FAIL basic_cw_valid_pulses got=%0d want=1", pulses); end
    total++; if (if0.word_count !== 16'd1) begin bad++; $display("FAIL basic_word_count got=%0d want=1", if0.word_count); end
  endtask

  task automatic test_ext();
    logic [7:0] s = '0;
    int n = 0, fpos = -1, lpos = -1;
    if1.in_data = 4'b0001; if1.in_valid = 1'b1; if1.bit_ready = 1'b1;
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
    total++; if (if1.cw_out !== 8'hB1 || if1.cw_valid !== 1'b1) begin bad++; $display("FAIL ext_cw_out got=%h/%b want=b1/1", if1.cw_out, if1.cw_valid); end
    for (int c = 0; c < 12; c++) begin
      if (if1.bit_valid) begin
        if (if1.bit_first) fpos = n;
        if (if1.bit_last) lpos = n;
        s = {s[6:0], if1.bit_out};
        n++;
      end
      @(posedge clk); #1;
    end
    total++; if (s !== 8'b10110001 || n != 8) begin bad++; $display("FAIL ext_serial got=%b n=%0d want=10110001 n=8", s, n); end
    total++; if (fpos != 0 || lpos != 7) begin bad++; $display("FAIL ext_first_last got=%0d/%0d want=0/7", fpos, lpos); end
  endtask

  task automatic test_back_to_back();
    logic [13:0] s = '0;
    logic [7:0] rdy = '0;
    int nv = 0, acc = 0;
    logic [15:0] wc0 = if0.word_count;
    if0.bit_ready = 1'b1; if0.in_data = 4'b1011; if0.in_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (c >= 1 && c <= 7) rdy[c] = if0.in_ready;
      if (if0.bit_valid) begin nv++; s = {s[12:0], if0.bit_out}; end
      if (if0.in_valid && if0.in_ready) acc++;
      @(posedge clk); #1;
      if (acc == 1) if0.in_data = 4'b0001;
      else if (acc >= 2) if0.in_valid = 1'b0;
    end
    total++; if (nv != 14 || acc != 2) begin bad++; $display("FAIL b2b_valid_cycles got=%0d acc=%0d want=14 acc=2", nv, acc); end
    total++; if (s !== 14'b0011011_0110001) begin bad++; $display("FAIL b2b_serial got=%b want=00110110110001", s); end
    total++; if (rdy[7:1] !== 7'b1000000) begin bad++; $display("FAIL b2b_in_ready got=%b want=1000000", rdy[7:1]); end
    total++; if (if0.word_count !== wc0 + 16'd2) begin bad++; $display("FAIL b2b_word_count got=%0d want=%0d", if0.word_count, wc0 + 16'd2); end
  endtask

  task automatic test_stall();
    logic [63:0] e64 = ref_cw(64'h6, 4, 3, 0);
    logic [6:0] exp = e64[6:0];
    logic [6:0] s = '0;
    logic [2:0] snap = '0;
    int n = 0;
    if0.in_data = 4'b0110; if0.in_valid = 1'b1; if0.bit_ready = 1'b1;
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
    for (int k = 1; k < 24 && n < 7; k++) begin
      if0.bit_ready = (k < 4 || k > 6);
      #1;
      if (k == 4) snap = {if0.bit_out, if0.bit_first, if0.bit_last};
      if (k > 4 && k <= 7) begin
        total++;
        if ({if0.bit_out, if0.bit_first, if0.bit_last} !== snap) begin bad++; $display("FAIL stall_frozen k=%0d got=%b want=%b", k, {if0.bit_out, if0.bit_first, if0.bit_last}, snap); end
      end
      if (k <= 6) begin
        total++;
        if (if0.in_ready !== 1'b0 || if0.bit_valid !== 1'b1) begin bad++; $display("FAIL stall_in_ready k=%0d got=%b valid=%b want=0 valid=1", k, if0.in_ready, if0.bit_valid); end
      end
      if (if0.bit_valid && if0.bit_ready) begin s = {s[5:0], if0.bit_out}; n++; end
      @(posedge clk); #1;
    end
    total++; if (s !== exp || n != 7) begin bad++; $display("FAIL stall_serial got=%b n=%0d want=%b n=7", s, n, exp); end
  endtask

  task automatic test_reset_mid();
    logic [6:0] s = '0;
    int n = 0;
    if0.in_data = 4'b1011; if0.in_valid = 1'b1; if0.bit_ready = 1'b1;
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    total++; if ({if0.bit_valid, if0.bit_out, if0.bit_first, if0.bit_last} !== 4'b0000) begin bad++; $display("FAIL midrst_bits got=%b want=0000", {if0.bit_valid, if0.bit_out, if0.bit_first, if0.bit_last}); end
    total++; if (if0.cw_out !== 7'h00 || if0.cw_valid !== 1'b0) begin bad++; $display("FAIL midrst_cw got=%h/%b want=00/0", if0.cw_out, if0.cw_valid); end
    total++; if (if0.word_count !== 16'd0 || if0.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_wc_ready got=%0d/%b want=0/1", if0.word_count, if0.in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    if0.in_data = 4'b0001; if0.in_valid = 1'b1;
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (if0.bit_valid) begin s = {s[5:0], if0.bit_out}; n++; end
      @(posedge clk); #1;
    end
    total++; if (s !== 7'b0110001 || n != 7) begin bad++; $display("FAIL midrst_serial got=%b n=%0d want=0110001 n=7", s, n); end
    total++; if (if0.word_count !== 16'd1) begin bad++; $display("FAIL midrst_word_count got=%0d want=1", if0.word_count); end
  endtask

  task automatic test_random();
    logic [14:0] q[$];
    logic [14:0] acc_bits = '0;
    logic [14:0] last_exp = '0;
    logic [14:0] got, exp;
    logic [63:0] e64;
    int sent = 0, done = 0, nb = 0, s, want;
    bit acc_flag = 0;
    ifw.in_valid = 1'b0; ifw.bit_ready = 1'b0;
    for (int c = 0; c < 60000 && done < 1000; c++) begin
      @(posedge clk); #1;
      if (acc_flag) begin
        total++;
        if (ifw.cw_valid !== 1'b1 || ifw.cw_out !== last_exp) begin bad++; $display("FAIL rand_cw_out got=%h/%b want=%h/1", ifw.cw_out, ifw.cw_valid, last_exp); end
        ifw.in_valid = 1'b0;
        acc_flag = 0;
      end else begin
        total++;
        if (ifw.cw_valid !== 1'b0) begin bad++; $display("FAIL rand_cw_valid_spurious got=%b want=0", ifw.cw_valid); end
      end
      if (!ifw.in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        ifw.in_data = 11'($urandom);
        ifw.in_valid = 1'b1;
      end
      ifw.bit_ready = $urandom_range(0, 2) != 0;
      #1;
      if (ifw.bit_valid && ifw.bit_ready) begin
        total++;
        if (ifw.bit_first !== (nb == 0) || ifw.bit_last !== (nb == 14)) begin bad++; $display("FAIL rand_flags bit=%0d got=%b%b", nb, ifw.bit_first, ifw.bit_last); end
        acc_bits = {acc_bits[13:0], ifw.bit_out};
        nb++;
        if (ifw.bit_last) begin
          got = acc_bits;
          exp = (q.size() > 0) ? q.pop_front() : ~acc_bits;
          total++;
          if (got !== exp || nb != 15) begin bad++; $display("FAIL rand_codeword word=%0d got=%h want=%h bits=%0d", done, got, exp, nb); end
          total++;
          if (syndrome11(got) != 0) begin bad++; $display("FAIL rand_syndrome_clean got=%0d want=0", syndrome11(got)); end
          for (int k = 0; k < 15; k++) begin
            s = syndrome11(got ^ (15'd1 << k));
            want = (k < 11) ? tb_pos(k) : (1 << (k - 11));
            total++;
            if (s != want || s == 0) begin bad++; $display("FAIL rand_syndrome_flip bit=%0d got=%0d want=%0d", k, s, want); end
          end
          nb = 0;
          done++;
        end
      end
      if (ifw.in_valid && ifw.in_ready) begin
        e64 = ref_cw(64'(ifw.in_data), 11, 4, 0);
        last_exp = e64[14:0];
        q.push_back(last_exp);
        sent++;
        acc_flag = 1;
      end
    end
    total++;
    if (done != 1000) begin bad++; $display("FAIL rand_timeout got=%0d want=1000 words", done); end
  endtask

  initial begin
    if0.in_data = '0; if0.in_valid = 1'b0; if0.bit_ready = 1'b0;
    if1.in_data = '0; if1.in_valid = 1'b0; if1.bit_ready = 1'b0;
    ifw.in_data = '0; ifw.in_valid = 1'b0; ifw.bit_ready = 1'b0;
    test_reset();
    test_basic();
    test_ext();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
